// File: rtl/ez8_isa_pkg.sv
// EZ8 instruction fields and fetch sequencer state encodings shared by the
// fetch controller and its helpers.
package ez8_isa_pkg;

    localparam int TARGET_W = 12;

    localparam logic [3:0] OP_GOTO = 4'hA;
    localparam logic [3:0] OP_CALL = 4'hB;
    localparam logic [3:0] OP_RET  = 4'hF;

    typedef enum logic [2:0] {
        S_REQ   = 3'd0,
        S_WAIT  = 3'd1,
        S_HOLD  = 3'd2,
        S_ISSUE = 3'd3,
        S_HALT  = 3'd4
    } fetch_state_e;

    function automatic logic [3:0] opcode_of(input logic [15:0] instr);
        return instr[15:12];
    endfunction

endpackage

// File: rtl/fetch_timeout.sv
// Loadable wait counter for the imem handshake; flags the cycle in which the
// configured number of unanswered wait cycles is reached (TIMEOUT=0 disables).
module fetch_timeout #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic en,
    output logic expired
);

    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Next count and terminal flag.
    always_comb begin
        count_d = count_q;
        expired = 1'b0;
        if (clear) begin
            count_d = '0;
        end else if (en) begin
            if ((TIMEOUT != 0) && (count_q == LAST)) begin
                expired = 1'b1;
            end else begin
                count_d = count_q + CNT_W'(1);
            end
        end else begin
            count_d = count_q;
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: fetches one word per step from imem, turns
// GOTO/CALL/RET into PC-controller pulses and forwards the rest to execute.
module fetch_ctrl import ez8_isa_pkg::*; #(
    parameter int ADDR_W  = 12,
    parameter int INSTR_W = 16,
    parameter int TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [ADDR_W-1:0]  pc_in,
    input  logic               kill_in,
    input  logic               stopped_in,
    input  logic               skip_cond,
    output logic               pause_out,
    output logic               goto,
    output logic               call,
    output logic               ret,
    output logic               skip,
    output logic [ADDR_W-1:0]  goto_addr,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_rvalid,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               ex_valid,
    input  logic               ex_ready,
    output logic [INSTR_W-1:0] ex_instr,
    output logic [ADDR_W-1:0]  ex_pc,
    output logic               fetch_error
);

    fetch_state_e       state_q, state_d;
    logic               pause_q, pause_d;
    logic               goto_q, goto_d;
    logic               call_q, call_d;
    logic               ret_q, ret_d;
    logic               skip_q, skip_d;
    logic               imem_req_q, imem_req_d;
    logic [ADDR_W-1:0]  imem_addr_q, imem_addr_d;
    logic               ex_valid_q, ex_valid_d;
    logic [INSTR_W-1:0] ex_instr_q, ex_instr_d;
    logic [ADDR_W-1:0]  ex_pc_q, ex_pc_d;
    logic               fetch_error_q, fetch_error_d;
    logic               skip_pending_q, skip_pending_d;
    logic [INSTR_W-1:0] ir_q, ir_d;
    logic [ADDR_W-1:0]  ir_pc_q, ir_pc_d;

    logic               slot_free_s;
    logic               issuing_s;
    logic               cnt_clear_s;
    logic               cnt_en_s;
    logic               cnt_expired_s;
    logic [INSTR_W-1:0] issue_instr_s;
    logic [ADDR_W-1:0]  issue_pc_s;

    fetch_timeout #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk     (clk),
        .reset   (reset),
        .clear   (cnt_clear_s),
        .en      (cnt_en_s),
        .expired (cnt_expired_s)
    );

    assign slot_free_s = !ex_valid_q || ex_ready;
    // Issue decisions are taken on the edge entering S_ISSUE, so the word may
    // still be on imem_rdata rather than in ir.
    assign issue_instr_s = (state_q == S_WAIT) ? imem_rdata  : ir_q;
    assign issue_pc_s    = (state_q == S_WAIT) ? imem_addr_q : ir_pc_q;

    // Next-state and registered-output computation.
    always_comb begin
        state_d        = state_q;
        pause_d        = 1'b1;
        goto_d         = 1'b0;
        call_d         = 1'b0;
        ret_d          = 1'b0;
        skip_d         = 1'b0;
        imem_req_d     = 1'b0;
        imem_addr_d    = imem_addr_q;
        ex_valid_d     = ex_valid_q && !ex_ready;
        ex_instr_d     = ex_instr_q;
        ex_pc_d        = ex_pc_q;
        fetch_error_d  = fetch_error_q;
        skip_pending_d = skip_pending_q || skip_cond;
        ir_d           = ir_q;
        ir_pc_d        = ir_pc_q;
        issuing_s      = 1'b0;
        cnt_clear_s    = 1'b0;
        cnt_en_s       = 1'b0;

        case (state_q)
            S_REQ: begin
                imem_req_d  = 1'b1;
                imem_addr_d = pc_in;
                cnt_clear_s = 1'b1;
                state_d     = S_WAIT;
            end
            S_WAIT: begin
                if (imem_rvalid) begin
                    ir_d    = imem_rdata;
                    ir_pc_d = imem_addr_q;
                    if (slot_free_s) begin
                        issuing_s = 1'b1;
                        state_d   = S_ISSUE;
                    end else begin
                        state_d   = S_HOLD;
                    end
                end else begin
                    cnt_en_s = 1'b1;
                    if (cnt_expired_s) begin
                        fetch_error_d = 1'b1;
                        state_d       = S_HALT;
                    end else begin
                        state_d       = S_WAIT;
                    end
                end
            end
            S_HOLD: begin
                if (slot_free_s) begin
                    issuing_s = 1'b1;
                    state_d   = S_ISSUE;
                end else begin
                    state_d   = S_HOLD;
                end
            end
            S_ISSUE: begin
                state_d = S_REQ;
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_HALT;
            end
        endcase

        if (stopped_in) begin
            state_d    = S_HALT;
            imem_req_d = 1'b0;
            issuing_s  = 1'b0;
        end else begin
            state_d    = state_d;
        end

        if (issuing_s) begin
            pause_d = 1'b0;
            if (skip_pending_q) begin
                skip_d         = 1'b1;
                skip_pending_d = skip_cond;
            end else if (kill_in) begin
                skip_d = 1'b0;
            end else begin
                case (opcode_of(issue_instr_s))
                    OP_GOTO: begin
                        goto_d = 1'b1;
                    end
                    OP_CALL: begin
                        goto_d = 1'b1;
                        call_d = 1'b1;
                    end
                    OP_RET: begin
                        ret_d = 1'b1;
                    end
                    default: begin
                        ex_valid_d = 1'b1;
                        ex_instr_d = issue_instr_s;
                        ex_pc_d    = issue_pc_s;
                    end
                endcase
            end
        end else begin
            pause_d = 1'b1;
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= S_REQ;
            pause_q        <= 1'b1;
            goto_q         <= 1'b0;
            call_q         <= 1'b0;
            ret_q          <= 1'b0;
            skip_q         <= 1'b0;
            imem_req_q     <= 1'b0;
            imem_addr_q    <= '0;
            ex_valid_q     <= 1'b0;
            ex_instr_q     <= '0;
            ex_pc_q        <= '0;
            fetch_error_q  <= 1'b0;
            skip_pending_q <= 1'b0;
            ir_q           <= '0;
            ir_pc_q        <= '0;
        end else begin
            state_q        <= state_d;
            pause_q        <= pause_d;
            goto_q         <= goto_d;
            call_q         <= call_d;
            ret_q          <= ret_d;
            skip_q         <= skip_d;
            imem_req_q     <= imem_req_d;
            imem_addr_q    <= imem_addr_d;
            ex_valid_q     <= ex_valid_d;
            ex_instr_q     <= ex_instr_d;
            ex_pc_q        <= ex_pc_d;
            fetch_error_q  <= fetch_error_d;
            skip_pending_q <= skip_pending_d;
            ir_q           <= ir_d;
            ir_pc_q        <= ir_pc_d;
        end
    end

    assign pause_out   = pause_q;
    assign goto        = goto_q;
    assign call        = call_q;
    assign ret         = ret_q;
    assign skip        = skip_q;
    assign goto_addr   = ADDR_W'(ir_q[TARGET_W-1:0]);
    assign imem_req    = imem_req_q;
    assign imem_addr   = imem_addr_q;
    assign ex_valid    = ex_valid_q;
    assign ex_instr    = ex_instr_q;
    assign ex_pc       = ex_pc_q;
    assign fetch_error = fetch_error_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed plus randomized bench for fetch_ctrl with an imem responder and a
// transaction-level model of issue outcomes and the execute slot.
module tb_fetch_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [11:0] pc_in = 12'h000;
    logic        kill_in = 1'b0;
    logic        stopped_in = 1'b0;
    logic        skip_cond = 1'b0;
    logic        pause_out, goto, call, ret, skip;
    logic [11:0] goto_addr;
    logic        imem_req;
    logic [11:0] imem_addr;
    logic        imem_rvalid = 1'b0;
    logic [15:0] imem_rdata = 16'h0000;
    logic        ex_valid;
    logic        ex_ready = 1'b1;
    logic [15:0] ex_instr;
    logic [11:0] ex_pc;
    logic        fetch_error;

    always #5 clk = ~clk;

    fetch_ctrl #(.ADDR_W(12), .INSTR_W(16), .TIMEOUT(4)) dut (
        .clk(clk), .reset(reset), .pc_in(pc_in), .kill_in(kill_in),
        .stopped_in(stopped_in), .skip_cond(skip_cond), .pause_out(pause_out),
        .goto(goto), .call(call), .ret(ret), .skip(skip), .goto_addr(goto_addr),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_rvalid(imem_rvalid),
        .imem_rdata(imem_rdata), .ex_valid(ex_valid), .ex_ready(ex_ready),
        .ex_instr(ex_instr), .ex_pc(ex_pc), .fetch_error(fetch_error)
    );

    int checks = 0;
    int failures = 0;
    int issues = 0;

    logic [15:0] mem [0:4095];
    logic        mem_enable = 1'b1;
    logic        mem_pending = 1'b0;
    logic [11:0] mem_addr = 12'h000;
    int          lat_cnt = 0;
    logic        rand_lat = 1'b0;
    logic        random_mode = 1'b0;
    logic        skip_with_rvalid = 1'b0;

    // Reference model state.
    logic        skip_pend_m = 1'b0;
    logic        sc_entry = 1'b0;
    logic [11:0] req_addr_m = 12'h000;
    logic        prev_pause = 1'b1;
    logic [27:0] exp_q [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // One clock: retire handshake, serve imem, then observe outputs at negedge.
    task automatic cycle();
        logic [15:0] ins;
        logic [3:0]  exp_p;
        logic        fwd;
        if (ex_valid === 1'b1 && ex_ready === 1'b1 && exp_q.size() != 0)
            void'(exp_q.pop_front());
        @(negedge clk);
        imem_rvalid = 1'b0;
        skip_cond = 1'b0;
        if (mem_pending) begin
            if (lat_cnt == 0) begin
                imem_rvalid = 1'b1;
                imem_rdata = mem[mem_addr];
                mem_pending = 1'b0;
                if (skip_with_rvalid) begin
                    skip_cond = 1'b1;
                    sc_entry = 1'b1;
                    skip_with_rvalid = 1'b0;
                end
            end else begin
                lat_cnt--;
            end
        end
        if (imem_req === 1'b1) begin
            check("imem_addr", {20'h0, imem_addr}, {20'h0, pc_in});
            req_addr_m = imem_addr;
            if (mem_enable) begin
                mem_pending = 1'b1;
                mem_addr = imem_addr;
                lat_cnt = rand_lat ? int'($urandom_range(0, 2)) : 0;
            end
        end
        if (pause_out === 1'b0) begin
            check("pause_single", {31'h0, prev_pause}, 32'h1);
            ins = mem[req_addr_m];
            exp_p = 4'b0000;
            fwd = 1'b0;
            if (skip_pend_m) exp_p = 4'b0001;
            else if (!kill_in) begin
                case (ins[15:12])
                    4'hA: exp_p = 4'b1000;
                    4'hB: exp_p = 4'b1100;
                    4'hF: exp_p = 4'b0010;
                    default: fwd = 1'b1;
                endcase
            end
            check("issue_pulses", {28'h0, goto, call, ret, skip}, {28'h0, exp_p});
            if (exp_p[3]) check("goto_addr", {20'h0, goto_addr}, {20'h0, ins[11:0]});
            if (fwd) exp_q.push_back({ins, req_addr_m});
            skip_pend_m = sc_entry;
            sc_entry = 1'b0;
            issues++;
            if (random_mode) begin
                pc_in = 12'($urandom);
                kill_in = ($urandom_range(0, 3) == 0);
                if ($urandom_range(0, 4) == 0) begin
                    skip_cond = 1'b1;
                    skip_pend_m = 1'b1;
                end
            end
        end else begin
            check("idle_pulses", {28'h0, goto, call, ret, skip}, 32'h0);
        end
        prev_pause = pause_out;
        check("ex_valid", {31'h0, ex_valid}, {31'h0, exp_q.size() != 0});
        if (ex_valid === 1'b1 && exp_q.size() != 0)
            check("ex_data", {4'h0, ex_instr, ex_pc}, {4'h0, exp_q[0]});
        if (random_mode) ex_ready = ($urandom_range(0, 1) == 1);
    endtask

    task automatic wait_issue(input string tag);
        int n = 0;
        do begin
            cycle();
            n++;
        end while (pause_out !== 1'b0 && n < 20);
        check(tag, {31'h0, pause_out}, 32'h0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        mem_pending = 1'b0;
        imem_rvalid = 1'b0;
        skip_cond = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_state", {24'h0, pause_out, goto, call, ret, skip, imem_req, ex_valid, fetch_error},
              32'h80);
        exp_q.delete();
        skip_pend_m = 1'b0;
        sc_entry = 1'b0;
        prev_pause = 1'b1;
        reset = 1'b0;
    endtask

    initial begin
        int base;
        for (int i = 0; i < 4096; i++) begin
            int sel;
            logic [3:0] op;
            sel = int'($urandom_range(0, 9));
            op = (sel == 0) ? 4'hA : (sel == 1) ? 4'hB : (sel == 2) ? 4'hF : 4'(sel);
            mem[i] = {op, 12'($urandom)};
        end
        mem[0] = 16'h1234; mem[1] = 16'hB05A; mem[2] = 16'h1111; mem[3] = 16'h2222;
        mem[4] = 16'h3333; mem[5] = 16'h4444; mem[6] = 16'h5555; mem[7] = 16'hA100;
        mem[8] = 16'hA100; mem[9] = 16'h6666; mem[10] = 16'h7777; mem[11] = 16'hF000;

        // 1: plain instruction forwarded, req one cycle after reset.
        pc_in = 12'h000;
        do_reset();
        cycle();
        check("t1_req_cyc1", {31'h0, imem_req}, 32'h1);
        wait_issue("t1_issue");
        check("t1_ex", {3'h0, ex_valid, ex_instr, ex_pc}, {3'h0, 1'b1, 16'h1234, 12'h000});

        // 2: CALL decoded into goto+call.
        pc_in = 12'h001;
        wait_issue("t2_issue");
        check("t2_call", {goto, call, goto_addr, ex_valid}, {1'b1, 1'b1, 12'h05A, 1'b0});

        // 3: skip pulse discards next word, following word forwarded.
        skip_cond = 1'b1; skip_pend_m = 1'b1; pc_in = 12'h002;
        wait_issue("t3_issue");
        check("t3_skip", {skip, ex_valid}, 2'b10);
        pc_in = 12'h003;
        wait_issue("t3_next");
        check("t3_fwd", {ex_valid, ex_instr, ex_pc}, {1'b1, 16'h2222, 12'h003});

        // Skip arriving on the consuming edge stays pending for the next fetch.
        skip_cond = 1'b1; skip_pend_m = 1'b1; skip_with_rvalid = 1'b1; pc_in = 12'h004;
        wait_issue("tb_skip_a");
        check("tb_skip_a_pulse", {31'h0, skip}, 32'h1);
        pc_in = 12'h005;
        wait_issue("tb_skip_b");
        check("tb_skip_b_pulse", {31'h0, skip}, 32'h1);
        pc_in = 12'h006;
        wait_issue("tb_skip_c");
        check("tb_skip_c_fwd", {ex_valid, ex_instr}, {1'b1, 16'h5555});

        // Skip and kill together: skip wins.
        skip_cond = 1'b1; skip_pend_m = 1'b1; kill_in = 1'b1; pc_in = 12'h007;
        wait_issue("tsk_issue");
        check("tsk_pulses", {goto, skip}, 2'b01);

        // 4: kill squashes a GOTO.
        pc_in = 12'h008;
        wait_issue("t4_issue");
        check("t4_kill", {goto, call, ret, skip, ex_valid}, 5'b00000);
        kill_in = 1'b0;

        // 5: execute stalls, second fetch parks in HOLD until ex_ready.
        ex_ready = 1'b0; pc_in = 12'h009;
        wait_issue("t5_first");
        pc_in = 12'h00A;
        repeat (6) cycle();
        check("t5_hold", {pause_out, ex_valid, ex_instr}, {1'b1, 1'b1, 16'h6666});
        ex_ready = 1'b1;
        cycle();
        check("t5_issue", {pause_out, ex_instr, ex_pc}, {1'b0, 16'h7777, 12'h00A});

        // Randomized fetch traffic.
        pc_in = 12'h00B;
        base = issues;
        random_mode = 1'b1; rand_lat = 1'b1;
        repeat (1500) cycle();
        random_mode = 1'b0; kill_in = 1'b0; ex_ready = 1'b1;
        check("rand_progress", {31'h0, (issues - base) >= 100}, 32'h1);

        // 6: imem never answers -> sticky error and no more requests.
        wait_issue("t6_last");
        mem_enable = 1'b0;
        begin
            int n = 0;
            do begin cycle(); n++; end while (imem_req !== 1'b1 && n < 10);
        end
        check("t6_req", {31'h0, imem_req}, 32'h1);
        repeat (3) cycle();
        check("t6_err_early", {31'h0, fetch_error}, 32'h0);
        cycle();
        check("t6_err", {31'h0, fetch_error}, 32'h1);
        for (int i = 0; i < 5; i++) begin
            cycle();
            check("t6_halt_req", {30'h0, imem_req, pause_out}, 32'h1);
        end
        mem_enable = 1'b1;
        do_reset();
        check("t6_err_clr", {31'h0, fetch_error}, 32'h0);

        // stopped_in halts fetching from the start.
        stopped_in = 1'b1;
        for (int i = 0; i < 8; i++) begin
            cycle();
            check("stop_req", {30'h0, imem_req, pause_out}, 32'h1);
        end
        stopped_in = 1'b0;
        pc_in = 12'h00B;
        do_reset();
        wait_issue("stop_recover");
        check("stop_recover_ret", {goto, ret, fetch_error}, 3'b010);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
